// File: rtl/bit_packer.sv
// bit_packer
//   Packs variable-length bit tokens MSB-first into a byte stream.
//   Tokens are appended below the bits already held in a left-justified
//   accumulator; whole bytes are peeled off the top into a single output
//   register with a valid/ready handshake. A token with flush_bit set pads
//   the stream to a byte boundary and the block drains before accepting
//   more input, signalling completion with a one-cycle flush_done pulse.
//
// Ports
//   clock, reset    : single clock, asynchronous active-high reset
//   input_enable    : token strobe (accepted when in_ready is high)
//   val             : token bits, right-justified
//   size_of_bit     : token length in bits (clamped to MAX_TOK)
//   flush_bit       : pad to byte boundary after this token and drain
//   in_ready        : packer can accept a token this cycle
//   out_valid       : out_data holds a byte
//   out_data        : packed byte, first bit in bit 7
//   out_ready       : consumer accepts byte
//   flush_done      : one-cycle pulse when a flush has fully drained
//   bytes_written   : bytes handshaken since reset (wraps)
//   overflow_err    : sticky, token presented while in_ready was low
//   size_err        : sticky, accepted token had size_of_bit > MAX_TOK

module bit_packer #(
    parameter int ACC_W   = 128,
    parameter int MAX_TOK = 64,
    parameter int CNT_W   = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               input_enable,
    input  logic [MAX_TOK-1:0] val,
    input  logic [63:0]        size_of_bit,
    input  logic               flush_bit,
    output logic               in_ready,
    output logic               out_valid,
    output logic [7:0]         out_data,
    input  logic               out_ready,
    output logic               flush_done,
    output logic [CNT_W-1:0]   bytes_written,
    output logic               overflow_err,
    output logic               size_err
);

    // Wide enough to hold ACC_W plus the 7 bits added when rounding up.
    localparam int FILL_W = $clog2(ACC_W + 8);
    localparam int N_W    = $clog2(MAX_TOK + 1);

    localparam logic [FILL_W-1:0] FILL_BYTE   = FILL_W'(8);
    localparam logic [FILL_W-1:0] FILL_PAD    = FILL_W'(7);
    localparam logic [FILL_W-1:0] FILL_IN_MAX = FILL_W'(ACC_W - MAX_TOK);
    localparam logic [N_W-1:0]    N_MAX       = N_W'(MAX_TOK);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [ACC_W-1:0]   acc, acc_next, acc_shift, tok_placed;
    logic [FILL_W-1:0]  fill, fill_next, fill_shift, fill_sum, fill_pad;
    logic [N_W-1:0]     n;
    logic [MAX_TOK-1:0] tok_masked, tok_lj;
    logic               too_big, emit, accept, drop, handshake;

    assign too_big   = size_of_bit > 64'(MAX_TOK);
    assign n         = too_big ? N_MAX : size_of_bit[N_W-1:0];
    assign accept    = input_enable && in_ready;
    assign drop      = input_enable && !in_ready;
    assign handshake = out_valid && out_ready;
    assign emit      = (fill >= FILL_BYTE) && (!out_valid || out_ready);

    // Mask to n bits, left-justify within MAX_TOK, then slide down below the
    // bits that remain after this cycle's emit shift. A shift by the full
    // width yields zero, which covers the n == 0 and n == MAX_TOK cases.
    assign tok_masked = val & ~({MAX_TOK{1'b1}} << n);
    assign tok_lj     = tok_masked << (N_MAX - n);
    assign acc_shift  = emit ? (acc << 8) : acc;
    assign fill_shift = emit ? (fill - FILL_BYTE) : fill;
    assign tok_placed = {tok_lj, {(ACC_W - MAX_TOK){1'b0}}} >> fill_shift;
    assign fill_sum   = fill_shift + FILL_W'(n);
    // Bits below fill are always zero, so padding is only a fill round-up.
    assign fill_pad   = fill_sum + FILL_PAD;

    always_comb begin
        acc_next  = acc_shift;
        fill_next = fill_shift;
        if (accept) begin
            acc_next  = acc_shift | tok_placed;
            fill_next = flush_bit ? {fill_pad[FILL_W-1:3], 3'b000} : fill_sum;
        end
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (accept && flush_bit) state_next = FLUSH;
            FLUSH:   if (fill == '0 && (!out_valid || out_ready)) state_next = DONE;
            DONE:    state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // FSM outputs; in_ready is held low while reset is asserted.
    always_comb begin
        in_ready   = (state == RUN) && (fill <= FILL_IN_MAX) && !reset;
        flush_done = (state == DONE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc           <= '0;
            fill          <= '0;
            out_valid     <= 1'b0;
            out_data      <= 8'h00;
            bytes_written <= '0;
            overflow_err  <= 1'b0;
            size_err      <= 1'b0;
        end else begin
            acc  <= acc_next;
            fill <= fill_next;
            if (emit) begin
                out_valid <= 1'b1;
                out_data  <= acc[ACC_W-1 -: 8];
            end else if (handshake) begin
                out_valid <= 1'b0;
            end
            if (handshake) begin
                bytes_written <= bytes_written + CNT_W'(1);
            end
            if (drop) begin
                overflow_err <= 1'b1;
            end
            if (accept && too_big) begin
                size_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bit_packer.sv
module tb_bit_packer;

    localparam int ACC_W   = 128;
    localparam int MAX_TOK = 64;
    localparam int CNT_W   = 32;

    logic               clock = 1'b0;
    logic               reset;
    logic               input_enable;
    logic [MAX_TOK-1:0] val;
    logic [63:0]        size_of_bit;
    logic               flush_bit;
    logic               in_ready;
    logic               out_valid;
    logic [7:0]         out_data;
    logic               out_ready;
    logic               flush_done;
    logic [CNT_W-1:0]   bytes_written;
    logic               overflow_err;
    logic               size_err;

    bit_packer #(.ACC_W(ACC_W), .MAX_TOK(MAX_TOK), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .input_enable(input_enable), .val(val),
        .size_of_bit(size_of_bit), .flush_bit(flush_bit), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .flush_done(flush_done), .bytes_written(bytes_written),
        .overflow_err(overflow_err), .size_err(size_err)
    );

    always #5 clock = ~clock;

    int compared   = 0;
    int mismatched = 0;

    // Behavioural model: a plain queue of the bits the stream must carry.
    bit         exp_q[$];
    int         nbits         = 0;
    int         hs_count      = 0;
    int         flush_pending = 0;
    int         flush_pulses  = 0;
    logic [7:0] cap[$];
    logic       prev_stall    = 1'b0;
    logic [7:0] prev_data     = 8'h00;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void push_token(input logic [63:0] v, input logic [63:0] s, input logic f);
        int n;
        n = (s > 64'd64) ? 64 : int'(s);
        for (int i = n - 1; i >= 0; i--) begin
            exp_q.push_back(v[i]);
            nbits++;
        end
        if (f) begin
            while (nbits % 8 != 0) begin
                exp_q.push_back(1'b0);
                nbits++;
            end
            flush_pending++;
        end
    endfunction

    // Compare process: everything sampled mid-cycle, describing the next edge.
    always @(negedge clock) begin
        if (reset) begin
            exp_q.delete();
            nbits         = 0;
            hs_count      = 0;
            flush_pending = 0;
            prev_stall    = 1'b0;
        end else begin
            check("bytes_written", 64'(bytes_written), 64'(hs_count));
            if (prev_stall) begin
                check("stall_valid", 64'(out_valid), 64'd1);
                check("stall_data", 64'(out_data), 64'(prev_data));
            end
            if (out_valid && out_ready) begin
                check("byte_expected", 64'(exp_q.size() >= 8), 64'd1);
                if (exp_q.size() >= 8) begin
                    logic [7:0] e;
                    e = 8'h00;
                    for (int i = 0; i < 8; i++) e = {e[6:0], exp_q.pop_front()};
                    check("out_byte", 64'(out_data), 64'(e));
                end
                cap.push_back(out_data);
                hs_count++;
            end
            if (flush_done) begin
                check("flush_done_ok", 64'(flush_pending == 1 && exp_q.size() == 0), 64'd1);
                if (flush_pending > 0) flush_pending--;
                flush_pulses++;
            end
            if (input_enable && in_ready) push_token(val, size_of_bit, flush_bit);
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [63:0] v, input logic [63:0] s, input logic f);
        input_enable = 1'b1;
        val          = v;
        size_of_bit  = s;
        flush_bit    = f;
        tick();
        input_enable = 1'b0;
        flush_bit    = 1'b0;
    endtask

    task automatic wait_flush(input string name);
        int c;
        c = 0;
        while (flush_pending != 0 && c < 300) begin
            tick();
            c++;
        end
        check(name, 64'(flush_pending == 0), 64'd1);
        tick();
    endtask

    task automatic check_bytes(input string name, input int cnt, input logic [127:0] exp);
        check({name, "_count"}, 64'(cap.size()), 64'(cnt));
        for (int i = 0; i < cnt && i < cap.size(); i++) begin
            check(name, 64'(cap[i]), 64'(exp[8*(cnt-1-i) +: 8]));
        end
        cap.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int pulses0;
        int c;
        reset        = 1'b1;
        input_enable = 1'b0;
        val          = '0;
        size_of_bit  = '0;
        flush_bit    = 1'b0;
        out_ready    = 1'b1;
        repeat (3) tick();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_bytes", 64'(bytes_written), 64'd0);
        check("rst_flush_done", 64'(flush_done), 64'd0);
        check("rst_errs", 64'({overflow_err, size_err}), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        reset = 1'b0;
        tick();
        check("in_ready_idle", 64'(in_ready), 64'd1);

        // Picture header
        pulses0 = flush_pulses;
        send(64'd8, 64'd5, 1'b0);
        send(64'd0, 64'd3, 1'b0);
        send(64'd0, 64'd32, 1'b0);
        send(64'd1, 64'd16, 1'b0);
        send(64'd0, 64'd2, 1'b0);
        send(64'd3, 64'd2, 1'b0);
        send(64'd0, 64'd4, 1'b1);
        wait_flush("hdr_flush");
        check_bytes("hdr", 8, 128'h4000_0000_0000_0130);
        check("hdr_pulses", 64'(flush_pulses - pulses0), 64'd1);
        check("hdr_bytes_written", 64'(bytes_written), 64'd8);
        check("hdr_errs", 64'({overflow_err, size_err}), 64'd0);

        // Short token with flush, including first-byte latency
        send(64'h5, 64'd3, 1'b1);
        check("lat_k", 64'(out_valid), 64'd0);
        tick();
        check("lat_k1_valid", 64'(out_valid), 64'd1);
        check("lat_k1_data", 64'(out_data), 64'hA0);
        wait_flush("a0_flush");
        check_bytes("a0", 1, 128'hA0);
        check("a0_bytes_written", 64'(bytes_written), 64'd9);

        // Oversized token
        check("size_err_before", 64'(size_err), 64'd0);
        send(64'h1FF, 64'd100, 1'b1);
        check("size_err_set", 64'(size_err), 64'd1);
        wait_flush("size_flush");
        check_bytes("size", 8, 128'h0000_0000_0000_01FF);

        // Backpressure and overflow
        out_ready    = 1'b0;
        input_enable = 1'b1;
        val          = '1;
        size_of_bit  = 64'd64;
        flush_bit    = 1'b0;
        check("bp_ready0", 64'(in_ready), 64'd1);
        tick();
        check("bp_ready1", 64'(in_ready), 64'd1);
        tick();
        check("bp_ready_full", 64'(in_ready), 64'd0);
        tick();
        input_enable = 1'b0;
        check("bp_overflow", 64'(overflow_err), 64'd1);
        repeat (4) tick();
        check("bp_stalled_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        c = 0;
        while ((out_valid || exp_q.size() != 0) && c < 100) begin
            tick();
            c++;
        end
        check_bytes("bp", 16, {128{1'b1}});
        check("bp_bytes_written", 64'(bytes_written), 64'd33);

        // Mid-stream reset
        out_ready = 1'b0;
        send(64'hAB, 64'd8, 1'b0);
        send(64'hCD, 64'd8, 1'b0);
        check("mr_held_data", 64'(out_data), 64'hAB);
        reset = 1'b1;
        tick();
        check("mr_valid", 64'(out_valid), 64'd0);
        check("mr_data", 64'(out_data), 64'd0);
        check("mr_bytes", 64'(bytes_written), 64'd0);
        check("mr_errs", 64'({overflow_err, size_err}), 64'd0);
        reset     = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();
        check("mr_no_stale", 64'(cap.size()), 64'd0);
        send(64'h12, 64'd8, 1'b1);
        wait_flush("mr_flush");
        check_bytes("mr", 1, 128'h12);
        check("mr_bytes_written", 64'(bytes_written), 64'd1);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            val       = {$urandom, $urandom};
            if (in_ready && $urandom_range(0, 1) == 1) begin
                input_enable = 1'b1;
                size_of_bit  = ($urandom_range(0, 31) == 0) ? 64'($urandom_range(65, 300))
                                                             : 64'($urandom_range(0, 64));
                flush_bit    = ($urandom_range(0, 15) == 0);
            end else begin
                input_enable = 1'b0;
                flush_bit    = 1'b0;
            end
            tick();
        end
        input_enable = 1'b0;
        flush_bit    = 1'b0;
        out_ready    = 1'b1;
        c = 0;
        while (!in_ready && c < 300) begin
            tick();
            c++;
        end
        check("rnd_ready_before_final", 64'(in_ready), 64'd1);
        send(64'd0, 64'd0, 1'b1);
        wait_flush("rnd_flush");
        check("rnd_residual_bits", 64'(exp_q.size()), 64'd0);
        check("rnd_out_idle", 64'(out_valid), 64'd0);
        check("rnd_no_overflow", 64'(overflow_err), 64'd0);
        check("rnd_bytes_written", 64'(bytes_written), 64'(hs_count));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
